aes_key_expand: RTL and testbench
=================================

# aes_key_expand

Iterative AES key-schedule generator sitting directly upstream of the AES cipher core. Accepts a cipher key of NK words and expands it one word per clock into all NB*(NR+1) schedule words, using a single shared SubWord. The cipher core reads the stored round keys through a random-access read port. The block supports 128-, 192- and 256-bit keys through the same NK/NR parameters as the core.

## Interface
- WORD, 32: word width in bits; only 32 is supported.
- NB, 4: data words per block; round-key width is WORD*NB.
- NK, 4: key words; legal values are 4, 6 and 8.
- NR, 10: rounds; must be 10, 12 or 14 for NK 4, 6 or 8 respectively.
- Local NW = NB*(NR+1): total schedule words (44, 52 or 60).
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_valid  in  1  a new key is presented.
- key_ready  out  1  the block can accept a key.
- key  in  WORD*NK  cipher key; w[0] = key[WORD*NK-1 -: WORD] (FIPS-197 byte order).
- rk_idx  in  $clog2(NR+1)  round-key select.
- rk  out  WORD*NB  {w[4r], w[4r+1], w[4r+2], w[4r+3]} for r = rk_idx, with w[4r] in the MSBs. Combinational read.
- keys_valid  out  1  the whole schedule for the last accepted key is stored.

## Operation
- FSM states are IDLE, EXPAND and DONE.
  - IDLE→EXPAND on handshake.
  - EXPAND→DONE when word NW-1 is written.
  - DONE→EXPAND on handshake.
- A handshake is key_valid && key_ready. key_ready = 1 in IDLE and DONE, and 0 in EXPAND.
- On handshake:
  - Write w[0..NK-1] from key.
  - Set i = NK, imod = 0 and rcon = 8'h01.
  - Clear keys_valid.
- Each EXPAND cycle:
  - temp = w[i-1].
  - If imod == 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon = xtime(rcon).
  - Else if NK == 8 and imod == 4: temp = SubWord(temp).
  - Write w[i] = w[i-NK] ^ temp.
  - Update counters: i++, and imod = (imod == NK-1) ? 0 : imod+1. No divider is used.
- There is exactly one SubWord instance (4 S-boxes).
- Storage is an NW x WORD register array, cleared by reset.
- rk_idx > NR: rk = 0.
- rk is readable at any time. While in EXPAND it shows partially updated words; consumers gate their reads on keys_valid.
- key_valid asserted during EXPAND is ignored. The key is not latched, and the requester holds it until key_ready.

## Timing
- Reset values:
  - state = IDLE, key_ready = 1, keys_valid = 0.
  - i = 0, imod = 0, rcon = 8'h01, all w = 0, so rk = 0.
- Handshake edge (edge 0): w[0..NK-1] are written.
  - key_ready falls and keys_valid falls after this edge.
- Edge k (k ≥ 1): w[NK+k-1] is written.
- The edge that writes w[NW-1] also:
  - sets keys_valid = 1 and key_ready = 1;
  - moves the state to DONE.
- Key-to-keys_valid latency is NW-NK edges: 40, 46 or 52.
- Rekey in DONE: keys_valid is 0 from the next cycle. The old schedule is overwritten progressively.
- Reset asserted mid-EXPAND clears everything immediately. No partial schedule survives and keys_valid stays 0.
- A handshake on the same edge as the last write cannot occur, because key_ready = 0 in EXPAND.

## Structure
- Shared package aes_pkg:
  - WORD and NB constants;
  - the S-box table as a function;
  - xtime();
  - FSM state enum typedef (IDLE, EXPAND, DONE).
- Sub-module aes_sub_word: combinational, 32-bit in/out, 4 S-box lookups. The cipher core reuses it.
- The top-level parameter set (NK, NR) is passed straight through from the design top.

## Test plan
- FIPS-197 A.1, NK = 4, key 2b7e151628aed2a6abf7158809cf4f3c:
  - keys_valid exactly 40 edges after the handshake;
  - rk[1] = a0fafe1788542cb123a339392a6c7605;
  - rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6.
- FIPS-197 A.2, NK = 6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - latency 46;
  - rk[12] = e98ba06f448c773c8ecc720401002202.
- FIPS-197 A.3, NK = 8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - latency 52;
  - rk[14] = fe4890d1e6188d0b046df344706c631e (checks the imod == 4 SubWord path).
- Handshake behaviour:
  - key_valid pulsed during EXPAND with a different key → ignored; final rk[10] is still the A.1 value.
  - Rekey from DONE with all-zero key → keys_valid low the next cycle.
  - After 40 edges, rk[10] = b4ef5bcb3e92e21123e951cf6f8f188e.
- Reset behaviour:
  - rst asserted 20 cycles into EXPAND → asynchronously key_ready = 1, keys_valid = 0, rk[0] = 0.
  - A fresh A.1 load after reset → correct results.
  - rk_idx = 11..15 → rk = 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants and helpers: word geometry, GF(2^8) arithmetic, S-box, FSM states.
package aes_pkg;

    localparam int WORD = 32;
    localparam int NB   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box built as x^254 (multiplicative inverse, 0 maps to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] t;
        logic [7:0] r;
        logic [7:0] b;
        t = gf_mul(x, x);
        r = t;
        for (int k = 2; k < 8; k++) begin
            t = gf_mul(t, t);
            r = gf_mul(r, t);
        end
        b = r;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [WORD-1:0] din,
    output logic [WORD-1:0] dout
);

    always_comb begin
        dout = '0;
        for (int b = 0; b < 4; b++) begin
            dout[8*b +: 8] = sbox(din[8*b +: 8]);
        end
    end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES key schedule: one schedule word per clock through a single shared SubWord,
// stored round keys exposed through a combinational random-access read port.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     key_valid,
    output logic                     key_ready,
    input  logic [WORD*NK-1:0]       key,
    input  logic [$clog2(NR+1)-1:0]  rk_idx,
    output logic [WORD*NB-1:0]       rk,
    output logic                     keys_valid
);

    localparam int NW = NB * (NR + 1);
    localparam int IW = $clog2(NW);
    localparam int RW = $clog2(NR + 1);

    state_t          state, state_nx;
    logic [WORD-1:0] w [NW];
    logic [IW-1:0]   i;
    logic [2:0]      imod;
    logic [7:0]      rcon;
    logic            handshake;
    logic            last_word;
    logic [WORD-1:0] prev, sw_in, sw_out, temp;

    assign key_ready = (state != EXPAND);
    assign handshake = key_valid && key_ready;
    assign last_word = (i == IW'(NW - 1));

    assign prev  = w[i - 1'b1];
    assign sw_in = (imod == 3'd0) ? {prev[WORD-9:0], prev[WORD-1 -: 8]} : prev;

    aes_sub_word u_sub_word (
        .din  (sw_in),
        .dout (sw_out)
    );

    always_comb begin
        temp = prev;
        if (imod == 3'd0) begin
            temp = sw_out ^ {rcon, 24'h000000};
        end else if (NK == 8 && imod == 3'd4) begin
            temp = sw_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (handshake) state_nx = EXPAND;
            EXPAND:  if (last_word) state_nx = DONE;
            DONE:    if (handshake) state_nx = EXPAND;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NW; j++) w[j] <= '0;
            i          <= '0;
            imod       <= '0;
            rcon       <= 8'h01;
            keys_valid <= 1'b0;
        end else if (handshake) begin
            for (int j = 0; j < NK; j++) w[j] <= key[WORD*NK-1-WORD*j -: WORD];
            i          <= IW'(NK);
            imod       <= '0;
            rcon       <= 8'h01;
            keys_valid <= 1'b0;
        end else if (state == EXPAND) begin
            w[i] <= w[i - IW'(NK)] ^ temp;
            i    <= i + 1'b1;
            imod <= (imod == 3'(NK - 1)) ? 3'd0 : imod + 3'd1;
            if (imod == 3'd0) rcon <= xtime(rcon);
            if (last_word) keys_valid <= 1'b1;
        end
    end

    always_comb begin
        rk = '0;
        if (rk_idx <= RW'(NR)) begin
            for (int b = 0; b < NB; b++) begin
                rk[WORD*(NB-1-b) +: WORD] = w[IW'(NB*int'(rk_idx) + b)];
            end
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: FIPS-197 vectors for all three key sizes, handshake and reset corners.
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   rk_idx = '0;

    logic         kv4 = 1'b0, kv6 = 1'b0, kv8 = 1'b0;
    logic         kr4, kr6, kr8;
    logic         ks4, ks6, ks8;
    logic [127:0] key4 = '0;
    logic [191:0] key6 = '0;
    logic [255:0] key8 = '0;
    logic [127:0] rk4, rk6, rk8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    aes_key_expand #(.NK(4), .NR(10)) u4 (
        .clk(clk), .rst(rst), .key_valid(kv4), .key_ready(kr4), .key(key4),
        .rk_idx(rk_idx), .rk(rk4), .keys_valid(ks4));
    aes_key_expand #(.NK(6), .NR(12)) u6 (
        .clk(clk), .rst(rst), .key_valid(kv6), .key_ready(kr6), .key(key6),
        .rk_idx(rk_idx), .rk(rk6), .keys_valid(ks6));
    aes_key_expand #(.NK(8), .NR(14)) u8 (
        .clk(clk), .rst(rst), .key_valid(kv8), .key_ready(kr8), .key(key8),
        .rk_idx(rk_idx), .rk(rk8), .keys_valid(ks8));

    typedef struct {
        int           scen;
        int           sel;
        logic [3:0]   idx;
        logic [127:0] exp;
    } vec_t;

    localparam logic [255:0] KEY_A1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY_A2 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] KEY_ALT = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};

    vec_t table_v[$];
    vec_t sb[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] get_rk(input int sel);
        case (sel)
            4:       return rk4;
            6:       return rk6;
            default: return rk8;
        endcase
    endfunction

    function automatic logic get_ks(input int sel);
        case (sel)
            4:       return ks4;
            6:       return ks6;
            default: return ks8;
        endcase
    endfunction

    function automatic logic get_kr(input int sel);
        case (sel)
            4:       return kr4;
            6:       return kr6;
            default: return kr8;
        endcase
    endfunction

    task automatic set_kv(input int sel, input logic v);
        case (sel)
            4:       kv4 = v;
            6:       kv6 = v;
            default: kv8 = v;
        endcase
    endtask

    // Drive a key for one handshake edge and queue that scenario's expected round keys.
    task automatic load(input int sel, input logic [255:0] k, input int scen, input string name);
        case (sel)
            4:       key4 = k[255:128];
            6:       key6 = k[255:64];
            default: key8 = k;
        endcase
        set_kv(sel, 1'b1);
        @(posedge clk); #1;
        set_kv(sel, 1'b0);
        check({name, " key_ready low after handshake"}, 128'(get_kr(sel)), 128'd0);
        check({name, " keys_valid low after handshake"}, 128'(get_ks(sel)), 128'd0);
        foreach (table_v[n]) if (table_v[n].scen == scen) sb.push_back(table_v[n]);
    endtask

    task automatic wait_done(input int sel, output int cnt);
        cnt = 0;
        while (cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
            if (get_ks(sel)) break;
        end
    endtask

    task automatic drain(input string name);
        vec_t v;
        while (sb.size() > 0) begin
            v = sb.pop_front();
            rk_idx = v.idx;
            #1;
            check($sformatf("%s rk%0d[%0d]", name, v.sel, v.idx), get_rk(v.sel), v.exp);
        end
    endtask

    initial begin
        int cnt;

        table_v.push_back('{1, 4, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c});
        table_v.push_back('{1, 4, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605});
        table_v.push_back('{1, 4, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
        table_v.push_back('{2, 6, 4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5});
        table_v.push_back('{2, 6, 4'd12, 128'he98ba06f448c773c8ecc720401002202});
        table_v.push_back('{3, 8, 4'd0,  128'h603deb1015ca71be2b73aef0857d7781});
        table_v.push_back('{3, 8, 4'd1,  128'h1f352c073b6108d72d9810a30914dff4});
        table_v.push_back('{3, 8, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e});
        table_v.push_back('{4, 4, 4'd1,  128'h62636363626363636263636362636363});
        table_v.push_back('{4, 4, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e});

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset key_ready", 128'(kr4), 128'd1);
        check("reset keys_valid", 128'(ks4), 128'd0);
        rk_idx = 4'd0; #1;
        check("reset rk0", rk4, 128'd0);
        @(posedge clk); #1;

        // A.1 / A.2 / A.3 with latency
        load(4, KEY_A1, 1, "A1");
        wait_done(4, cnt);
        check("A1 latency", 128'(cnt), 128'd40);
        check("A1 key_ready at done", 128'(kr4), 128'd1);
        drain("A1");

        load(6, KEY_A2, 2, "A2");
        wait_done(6, cnt);
        check("A2 latency", 128'(cnt), 128'd46);
        drain("A2");

        load(8, KEY_A3, 3, "A3");
        wait_done(8, cnt);
        check("A3 latency", 128'(cnt), 128'd52);
        drain("A3");

        // Rekey from DONE with all-zero key
        load(4, 256'h0, 4, "zero");
        wait_done(4, cnt);
        check("zero latency", 128'(cnt), 128'd40);
        drain("zero");

        // key_valid during EXPAND with another key is ignored
        load(4, KEY_A1, 1, "ign");
        repeat (5) @(posedge clk);
        #1;
        key4 = KEY_ALT[255:128];
        kv4  = 1'b1;
        check("ign key_ready in expand", 128'(kr4), 128'd0);
        @(posedge clk); #1;
        kv4 = 1'b0;
        wait_done(4, cnt);
        check("ign latency", 128'(cnt + 6), 128'd40);
        drain("ign");

        // Asynchronous reset mid-expansion
        load(4, KEY_A1, 0, "rst");
        repeat (20) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid rst key_ready", 128'(kr4), 128'd1);
        check("mid rst keys_valid", 128'(ks4), 128'd0);
        rk_idx = 4'd0; #1;
        check("mid rst rk0", rk4, 128'd0);
        rk_idx = 4'd10; #1;
        check("mid rst rk10", rk4, 128'd0);
        @(posedge clk); #1;
        check("rst held keys_valid", 128'(ks4), 128'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        load(4, KEY_A1, 1, "post rst");
        wait_done(4, cnt);
        check("post rst latency", 128'(cnt), 128'd40);
        drain("post rst");

        for (int n = 11; n <= 15; n++) begin
            rk_idx = 4'(n); #1;
            check($sformatf("rk4 idx %0d out of range", n), rk4, 128'd0);
        end
        rk_idx = 4'd15; #1;
        check("rk8 idx 15 out of range", rk8, 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
